// File: rtl/data_mem_stage.sv
// Load/store stage behind the 64-bit ALU: little-endian 64-bit-wide data array with
// a fixed-latency request/response handshake and alignment/range/illegal-op flags.
module data_mem_stage #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        resp_valid,
    output logic [63:0] rdata,
    output logic [1:0]  err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic [63:0] mem [DEPTH_WORDS];

    logic        read_p0, write_p0, uns_p0;
    logic [1:0]  size_p0;
    logic [63:0] addr_p0, wdata_p0;

    logic        cur_read, cur_write, cur_uns;
    logic [1:0]  cur_size;
    logic [63:0] cur_addr, cur_wdata, cur_word, rdata_d;
    logic [AW-1:0] cur_idx;
    logic [2:0]  cur_off;
    logic [1:0]  err_d;
    logic        accept, enter_resp, we;

    function automatic logic [1:0] check_err(input logic rd, input logic wr,
                                             input logic [63:0] a, input logic [1:0] sz);
        logic [2:0] amask;
        amask = (sz == 2'd0) ? 3'b000 : (sz == 2'd1) ? 3'b001 :
                (sz == 2'd2) ? 3'b011 : 3'b111;
        if (rd == wr)                   return 2'b11;
        else if ((a[2:0] & amask) != 3'b000) return 2'b01;
        else if (a[63:AW+3] != '0)      return 2'b10;
        else                            return 2'b00;
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] dword, input logic [2:0] off,
                                                input logic [1:0] sz, input logic uns);
        logic [63:0] sh;
        sh = dword >> {off, 3'b000};
        case (sz)
            2'd0:    return uns ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            2'd1:    return uns ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'd2:    return uns ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: return sh;
        endcase
    endfunction

    function automatic logic [63:0] store_merge(input logic [63:0] old, input logic [63:0] wd,
                                                input logic [2:0] off, input logic [1:0] sz);
        logic [7:0]  be_base, be;
        logic [63:0] mask, data;
        be_base = (sz == 2'd0) ? 8'h01 : (sz == 2'd1) ? 8'h03 :
                  (sz == 2'd2) ? 8'h0F : 8'hFF;
        be   = be_base << off;
        data = wd << {off, 3'b000};
        for (int k = 0; k < 8; k++) mask[8*k +: 8] = {8{be[k]}};
        return (old & ~mask) | (data & mask);
    endfunction

    assign req_ready = rst_n && (state == IDLE);
    assign accept    = req_valid && req_ready;

    // In IDLE the live inputs are used so a LATENCY==1 build can finish on the accept edge.
    assign cur_read  = (state == IDLE) ? mem_read    : read_p0;
    assign cur_write = (state == IDLE) ? mem_write   : write_p0;
    assign cur_uns   = (state == IDLE) ? unsigned_ld : uns_p0;
    assign cur_size  = (state == IDLE) ? size        : size_p0;
    assign cur_addr  = (state == IDLE) ? addr        : addr_p0;
    assign cur_wdata = (state == IDLE) ? wdata       : wdata_p0;

    assign cur_idx  = cur_addr[AW+2:3];
    assign cur_off  = cur_addr[2:0];
    assign cur_word = mem[cur_idx];
    assign err_d    = check_err(cur_read, cur_write, cur_addr, cur_size);
    assign rdata_d  = ((err_d != 2'b00) || !cur_read) ? '0
                    : load_extend(cur_word, cur_off, cur_size, cur_uns);

    assign enter_resp = ((state == IDLE) && accept && (LATENCY == 1)) ||
                        ((state == BUSY) && (cnt == CW'(1)));
    assign we = enter_resp && (err_d == 2'b00) && cur_write;

    always_ff @(posedge clk) begin
        if (accept) begin
            read_p0  <= mem_read;
            write_p0 <= mem_write;
            uns_p0   <= unsigned_ld;
            size_p0  <= size;
            addr_p0  <= addr;
            wdata_p0 <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[cur_idx] <= store_merge(cur_word, cur_wdata, cur_off, cur_size);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            rdata      <= '0;
            err        <= 2'b00;
        end else begin
            resp_valid <= enter_resp;
            if (enter_resp) begin
                rdata <= rdata_d;
                err   <= err_d;
            end
            case (state)
                IDLE: if (accept) begin
                    cnt   <= CW'(LATENCY - 1);
                    state <= (LATENCY == 1) ? RESP : BUSY;
                end
                BUSY: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage: scoreboard of expected responses (value, error,
// arrival cycle) checked against a LATENCY=2 instance, plus a LATENCY=1 instance.
module tb_data_mem_stage;

    localparam int L0 = 2;

    logic        clk;
    logic        rst_n;
    logic        req_valid, mem_read, mem_write, unsigned_ld;
    logic [1:0]  size;
    logic [63:0] addr, wdata;
    logic        req_ready, resp_valid;
    logic [63:0] rdata;
    logic [1:0]  err;

    logic        r1_valid, r1_read, r1_write, r1_uns;
    logic [1:0]  r1_size;
    logic [63:0] r1_addr, r1_wdata;
    logic        r1_ready, r1_resp;
    logic [63:0] r1_rdata;
    logic [1:0]  r1_err;

    typedef struct {
        logic [63:0] rd;
        logic [1:0]  er;
        int          cy;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    data_mem_stage #(.DEPTH_WORDS(1024), .LATENCY(L0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write), .size(size), .unsigned_ld(unsigned_ld),
        .addr(addr), .wdata(wdata), .resp_valid(resp_valid), .rdata(rdata), .err(err)
    );

    data_mem_stage #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(r1_valid), .req_ready(r1_ready),
        .mem_read(r1_read), .mem_write(r1_write), .size(r1_size), .unsigned_ld(r1_uns),
        .addr(r1_addr), .wdata(r1_wdata), .resp_valid(r1_resp), .rdata(r1_rdata), .err(r1_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [63:0] a, input logic [63:0] wd);
        mem_read = rd; mem_write = wr; size = sz; unsigned_ld = uns; addr = a; wdata = wd;
        req_valid = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    task automatic req(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [63:0] a, input logic [63:0] wd,
                       input logic [63:0] erd, input logic [1:0] eer);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        drive(rd, wr, sz, uns, a, wd);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready", 64'(req_ready), 64'd1);
        e.rd = erd; e.er = eer; e.cy = cyc + L0;
        q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        drain();
    endtask

    // Response side of the scoreboard for the LATENCY=2 instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 64'(resp_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("resp_cycle", 64'(cyc), 64'(e.cy));
                    chk("rdata", rdata, e.rd);
                    chk("err", 64'(err), 64'(e.er));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'd0;
        unsigned_ld = 1'b0; addr = '0; wdata = '0;
        r1_valid = 1'b0; r1_read = 1'b0; r1_write = 1'b0; r1_size = 2'd0;
        r1_uns = 1'b0; r1_addr = '0; r1_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 64'(req_ready), 64'd1);

        req(1'b0, 1'b1, 2'd3, 1'b0, 64'h10, 64'h8877665544332211, 64'h0, 2'b00);
        req(1'b1, 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 64'h8877665544332211, 2'b00);
        req(1'b0, 1'b1, 2'd0, 1'b0, 64'h13, 64'h00000000000000AB, 64'h0, 2'b00);
        req(1'b1, 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 64'h88776655AB332211, 2'b00);
        req(1'b1, 1'b0, 2'd0, 1'b0, 64'h13, 64'h0, 64'hFFFFFFFFFFFFFFAB, 2'b00);
        req(1'b1, 1'b0, 2'd0, 1'b1, 64'h13, 64'h0, 64'h00000000000000AB, 2'b00);
        req(1'b1, 1'b0, 2'd2, 1'b0, 64'h14, 64'h0, 64'hFFFFFFFF88776655, 2'b00);
        req(1'b1, 1'b0, 2'd1, 1'b0, 64'h12, 64'h0, 64'hFFFFFFFFFFFFAB33, 2'b00);
        req(1'b1, 1'b0, 2'd1, 1'b1, 64'h12, 64'h0, 64'h000000000000AB33, 2'b00);
        req(1'b1, 1'b0, 2'd1, 1'b0, 64'h11, 64'h0, 64'h0, 2'b01);
        req(1'b0, 1'b1, 2'd1, 1'b0, 64'h16, 64'h123456789ABCBEEF, 64'h0, 2'b00);
        req(1'b1, 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 64'hBEEF6655AB332211, 2'b00);
        req(1'b1, 1'b0, 2'd2, 1'b1, 64'h14, 64'h0, 64'h00000000BEEF6655, 2'b00);
        req(1'b0, 1'b1, 2'd2, 1'b0, 64'h12, 64'hFFFFFFFFFFFFFFFF, 64'h0, 2'b01);
        req(1'b0, 1'b1, 2'd3, 1'b0, 64'h0, 64'h0000000000001111, 64'h0, 2'b00);
        req(1'b0, 1'b1, 2'd3, 1'b0, 64'h2000, 64'hDEADBEEFDEADBEEF, 64'h0, 2'b10);
        req(1'b1, 1'b0, 2'd3, 1'b0, 64'h0, 64'h0, 64'h0000000000001111, 2'b00);
        req(1'b1, 1'b1, 2'd3, 1'b0, 64'h10, 64'h0, 64'h0, 2'b11);
        req(1'b0, 1'b0, 2'd0, 1'b0, 64'h10, 64'h0, 64'h0, 2'b11);

        // req_valid held high: one accept every LATENCY+1 cycles, unsigned_ld ignored for dword
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd3, 1'b1, 64'h10, 64'h0);
        for (int k = 0; k < 9; k++) begin
            chk("hold_ready", 64'(req_ready), 64'((k % 3) == 0));
            if (req_ready) begin
                exp_t e;
                e.rd = 64'hBEEF6655AB332211; e.er = 2'b00; e.cy = cyc + L0;
                q.push_back(e);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        drain();

        // store aborted by reset while BUSY
        req(1'b0, 1'b1, 2'd3, 1'b0, 64'h18, 64'h1, 64'h0, 2'b00);
        req(1'b1, 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 64'hBEEF6655AB332211, 2'b00);
        @(negedge clk);
        drive(1'b0, 1'b1, 2'd3, 1'b0, 64'h18, 64'h2);
        chk("abort_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_busy_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_rst_ready", 64'(req_ready), 64'd0);
        chk("abort_rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("abort_rst_rdata", rdata, 64'd0);
        chk("abort_rst_err", 64'(err), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        req(1'b1, 1'b0, 2'd3, 1'b0, 64'h18, 64'h0, 64'h1, 2'b00);

        // LATENCY=1 instance: back-to-back every 2 cycles, response one cycle after accept
        @(negedge clk);
        r1_read = 1'b0; r1_write = 1'b1; r1_size = 2'd3; r1_uns = 1'b0;
        r1_addr = 64'h8; r1_wdata = 64'h000000000000CAFE; r1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("l1_ready", 64'(r1_ready), 64'((k % 2) == 0));
            chk("l1_resp_valid", 64'(r1_resp), 64'((k % 2) == 1));
            @(negedge clk);
        end
        r1_read = 1'b1; r1_write = 1'b0;
        @(negedge clk);
        r1_valid = 1'b0;
        chk("l1_ld_resp_valid", 64'(r1_resp), 64'd1);
        chk("l1_ld_rdata", r1_rdata, 64'h000000000000CAFE);
        chk("l1_ld_err", 64'(r1_err), 64'd0);
        @(negedge clk);
        chk("l1_resp_pulse", 64'(r1_resp), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
